sram_controller: RTL and testbench

- Memory responder that serves the MEM stage's data-memory read/write requests from an external 16-bit-wide SRAM.
- Each 32-bit access is split into two 16-bit SRAM accesses. `ready` holds low while a request is in progress, which stalls the pipeline through the hazard/freeze path.
- Sits between the MEM stage (initiator) and the SRAM pins. It replaces the single-cycle data memory.

---
 rtl/sram_controller_pkg.sv | 21 ++
 rtl/sram_controller.sv | 125 ++++++++++++
 tb/tb_sram_controller.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared constants for the MEM-stage SRAM controller: FSM encoding,
// parameter defaults and half-word select values.
package sram_controller_pkg;

   localparam int BASE_ADDR_DEFAULT     = 1024;
   localparam int ACCESS_CYCLES_DEFAULT = 2;
   localparam int SRAM_AW_DEFAULT       = 18;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE  = 3'd0;
   localparam state_t S_RD_LO = 3'd1;
   localparam state_t S_RD_HI = 3'd2;
   localparam state_t S_WR_LO = 3'd3;
   localparam state_t S_WR_HI = 3'd4;
   localparam state_t S_DONE  = 3'd5;

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

endpackage

// File: rtl/sram_controller.sv
// Serves 32-bit MEM-stage loads/stores from a 16-bit SRAM as two half-word
// accesses, holding ready low (pipeline freeze) until the access completes.
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter int BASE_ADDR     = BASE_ADDR_DEFAULT,
   parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT,
   parameter int SRAM_AW       = SRAM_AW_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               MEM_R_EN,
   input  logic               MEM_W_EN,
   input  logic [31:0]        address,
   input  logic [31:0]        writeData,
   output logic [31:0]        readData,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic [15:0]        SRAM_DQ_out,
   input  logic [15:0]        SRAM_DQ_in,
   output logic               SRAM_DQ_oe,
   output logic               SRAM_WE_N,
   output logic               SRAM_OE_N
);

   localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [31:0]      offset;
   logic [SRAM_AW-2:0] word;
   logic             last;
   logic             unused_offset;

   // Out-of-range addresses wrap silently into the SRAM word space.
   assign offset        = address - 32'(BASE_ADDR);
   assign word          = offset[SRAM_AW:2];
   assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};
   assign last          = (cnt == CW'(ACCESS_CYCLES - 1));

   assign ready = ~(MEM_R_EN | MEM_W_EN) | (state == S_DONE);

   // NOTE: SRAM pins are registered and updated on the edge that enters a
   // state, so the SRAM never sees a combinational glitch on its strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         readData    <= '0;
         SRAM_ADDR   <= '0;
         SRAM_DQ_out <= '0;
         SRAM_DQ_oe  <= 1'b0;
         SRAM_WE_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (MEM_W_EN) begin
                  state       <= S_WR_LO;
                  SRAM_ADDR   <= {word, HALF_LO};
                  SRAM_DQ_out <= writeData[15:0];
                  SRAM_DQ_oe  <= 1'b1;
                  SRAM_WE_N   <= 1'b0;
               end else if (MEM_R_EN) begin
                  state     <= S_RD_LO;
                  SRAM_ADDR <= {word, HALF_LO};
                  SRAM_OE_N <= 1'b0;
               end
            end
            S_RD_LO: begin
               if (last) begin
                  cnt            <= '0;
                  readData[15:0] <= SRAM_DQ_in;
                  state          <= S_RD_HI;
                  SRAM_ADDR      <= {word, HALF_HI};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RD_HI: begin
               if (last) begin
                  cnt             <= '0;
                  readData[31:16] <= SRAM_DQ_in;
                  state           <= S_DONE;
                  SRAM_OE_N       <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WR_LO: begin
               if (last) begin
                  cnt         <= '0;
                  state       <= S_WR_HI;
                  SRAM_ADDR   <= {word, HALF_HI};
                  SRAM_DQ_out <= writeData[31:16];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_WR_HI: begin
               if (last) begin
                  cnt        <= '0;
                  state      <= S_DONE;
                  SRAM_WE_N  <= 1'b1;
                  SRAM_DQ_oe <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state      <= S_IDLE;
               cnt        <= '0;
               SRAM_WE_N  <= 1'b1;
               SRAM_OE_N  <= 1'b1;
               SRAM_DQ_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (ACCESS_CYCLES 2 and 3), each on a
// behavioural SRAM, checked every cycle against a transaction-level model.
module sram_model #(
   parameter int AW = 18
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   dq_w,
   output logic [15:0]   dq_r,
   input  logic          we_n,
   input  logic          oe_n
);
   logic [15:0] mem [0:(1<<AW)-1];
   logic          pend;
   logic [AW-1:0] pend_a;
   logic [15:0]   pend_d;
   logic          rst_last;

   initial begin
      for (int k = 0; k < (1 << AW); k++) mem[k] = 16'h0000;
      pend = 1'b0;
      pend_a = '0;
      pend_d = '0;
      rst_last = 1'b0;
   end

   assign dq_r = oe_n ? 16'h0000 : mem[addr];

   // A write commits when its window closes (address moves or WE_N rises);
   // a window closed by a controller reset is discarded.
   always @(negedge clk) begin
      if (!we_n) begin
         if (pend && pend_a != addr) mem[pend_a] = pend_d;
         pend   = 1'b1;
         pend_a = addr;
         pend_d = dq_w;
      end else begin
         if (pend && !rst_last) mem[pend_a] = pend_d;
         pend = 1'b0;
      end
      rst_last = rst;
   end
endmodule

module tb_sram_controller;
   localparam int AC0 = 2;
   localparam int AC1 = 3;

   logic              clk;
   logic [1:0]        rst;
   logic [1:0]        r_en, w_en;
   logic [1:0][31:0]  addr, wdata, rdata;
   logic [1:0]        ready;
   logic [1:0][17:0]  s_addr;
   logic [1:0][15:0]  dq_out, dq_in;
   logic [1:0]        dq_oe, we_n, oe_n;

   int n_vec = 0;
   int n_bad = 0;
   bit started = 1'b0;

   // Transaction-level model state, one slot per instance.
   bit          m_busy [2];
   int          m_t    [2];
   bit          m_wr   [2];
   int          m_word [2];
   logic [31:0] m_wd   [2];
   logic [31:0] m_rd   [2];
   logic [15:0] m_mem  [2][64];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sram_controller #(.ACCESS_CYCLES(AC0)) dut0 (
      .clk(clk), .rst(rst[0]), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]),
      .address(addr[0]), .writeData(wdata[0]), .readData(rdata[0]),
      .ready(ready[0]), .SRAM_ADDR(s_addr[0]), .SRAM_DQ_out(dq_out[0]),
      .SRAM_DQ_in(dq_in[0]), .SRAM_DQ_oe(dq_oe[0]), .SRAM_WE_N(we_n[0]),
      .SRAM_OE_N(oe_n[0]));

   sram_controller #(.ACCESS_CYCLES(AC1)) dut1 (
      .clk(clk), .rst(rst[1]), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]),
      .address(addr[1]), .writeData(wdata[1]), .readData(rdata[1]),
      .ready(ready[1]), .SRAM_ADDR(s_addr[1]), .SRAM_DQ_out(dq_out[1]),
      .SRAM_DQ_in(dq_in[1]), .SRAM_DQ_oe(dq_oe[1]), .SRAM_WE_N(we_n[1]),
      .SRAM_OE_N(oe_n[1]));

   sram_model u_sram0 (.clk(clk), .rst(rst[0]), .addr(s_addr[0]), .dq_w(dq_out[0]),
                       .dq_r(dq_in[0]), .we_n(we_n[0]), .oe_n(oe_n[0]));
   sram_model u_sram1 (.clk(clk), .rst(rst[1]), .addr(s_addr[1]), .dq_w(dq_out[1]),
                       .dq_r(dq_in[1]), .we_n(we_n[1]), .oe_n(oe_n[1]));

   function automatic int ac_of(input int i);
      return (i == 0) ? AC0 : AC1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_busy[i] = 1'b0; m_t[i] = 0; m_wr[i] = 1'b0; m_word[i] = 0;
         m_wd[i] = '0; m_rd[i] = '0;
         for (int k = 0; k < 64; k++) m_mem[i][k] = 16'h0000;
      end
   end

   // Model: a request seen in an idle cycle occupies cycles 1..2*ac+1; the
   // low half completes at the end of cycle ac, the high half at cycle 2*ac.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int ac;
         ac = ac_of(i);
         if (rst[i]) begin
            m_busy[i] = 1'b0;
            m_rd[i]   = '0;
         end else if (!m_busy[i]) begin
            if (r_en[i] || w_en[i]) begin
               m_busy[i] = 1'b1;
               m_t[i]    = 1;
               m_wr[i]   = w_en[i];
               m_word[i] = int'(((addr[i] - 32'd1024) >> 2) & 32'h1FFFF);
               m_wd[i]   = wdata[i];
            end
         end else begin
            if (m_t[i] == ac) begin
               if (m_wr[i]) m_mem[i][(m_word[i] * 2) & 63] = m_wd[i][15:0];
               else         m_rd[i][15:0] = m_mem[i][(m_word[i] * 2) & 63];
            end
            if (m_t[i] == 2 * ac) begin
               if (m_wr[i]) m_mem[i][(m_word[i] * 2 + 1) & 63] = m_wd[i][31:16];
               else         m_rd[i][31:16] = m_mem[i][(m_word[i] * 2 + 1) & 63];
            end
            if (m_t[i] == 2 * ac + 1) m_busy[i] = 1'b0;
            else                      m_t[i]++;
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 2; i++) begin
            int ac;
            bit active, hi, rd_mid;
            ac     = ac_of(i);
            active = m_busy[i] && (m_t[i] <= 2 * ac);
            hi     = (m_t[i] > ac);
            rd_mid = active && !m_wr[i];
            check($sformatf("ready%0d", i), 32'(ready[i]),
                  m_busy[i] ? 32'(m_t[i] == 2 * ac + 1) : 32'(!(r_en[i] || w_en[i])));
            if (active && m_wr[i]) begin
               check($sformatf("we_n%0d", i), 32'(we_n[i]), 32'd0);
               check($sformatf("oe_n%0d", i), 32'(oe_n[i]), 32'd1);
               check($sformatf("dq_oe%0d", i), 32'(dq_oe[i]), 32'd1);
               check($sformatf("dq_out%0d", i), 32'(dq_out[i]),
                     hi ? 32'(m_wd[i][31:16]) : 32'(m_wd[i][15:0]));
            end else if (active) begin
               check($sformatf("we_n%0d", i), 32'(we_n[i]), 32'd1);
               check($sformatf("oe_n%0d", i), 32'(oe_n[i]), 32'd0);
               check($sformatf("dq_oe%0d", i), 32'(dq_oe[i]), 32'd0);
            end else begin
               check($sformatf("we_n%0d", i), 32'(we_n[i]), 32'd1);
               check($sformatf("oe_n%0d", i), 32'(oe_n[i]), 32'd1);
               check($sformatf("dq_oe%0d", i), 32'(dq_oe[i]), 32'd0);
            end
            if (m_busy[i])
               check($sformatf("sram_addr%0d", i), 32'(s_addr[i]),
                     32'((m_word[i] * 2) + ((m_t[i] > ac) ? 1 : 0)) & 32'h3FFFF);
            if (!rd_mid)
               check($sformatf("readData%0d", i), rdata[i], m_rd[i]);
         end
      end
   end

   // Presents a request at the current cycle (caller is just past a rising
   // edge), waits for ready and checks its latency, then steps past that edge.
   task automatic access(input int i, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
      int lat;
      lat = -1;
      r_en[i] = rd; w_en[i] = wr; addr[i] = a; wdata[i] = d;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ready[i]) begin
            lat = c;
            break;
         end
      end
      check($sformatf("latency%0d", i), 32'(lat), 32'(2 * ac_of(i) + 1));
      @(posedge clk); #1;
   endtask

   task automatic idle(input int i, input int n);
      r_en[i] = 1'b0; w_en[i] = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 2'b11; r_en = '0; w_en = '0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 2'b00;
      started = 1'b1;
      check("reset_ready", 32'(ready[0]), 32'd1);
      check("reset_readData", rdata[0], 32'h0);
      check("reset_addr", 32'(s_addr[0]), 32'h0);
      @(posedge clk); #1;

      // Write then read at the base address.
      access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
      idle(0, 1);
      check("sram0_w0", 32'(u_sram0.mem[0]), 32'h0000BEEF);
      check("sram0_w1", 32'(u_sram0.mem[1]), 32'h0000DEAD);
      check("model_mem0", 32'(m_mem[0][0]), 32'h0000BEEF);
      access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      check("read_1024", rdata[0], 32'hDEADBEEF);
      check("model_rd", m_rd[0], 32'hDEADBEEF);
      idle(0, 1);

      // Address offset.
      access(0, 1'b0, 1'b1, 32'd1036, 32'h12345678);
      idle(0, 1);
      check("sram0_w6", 32'(u_sram0.mem[6]), 32'h00005678);
      check("sram0_w7", 32'(u_sram0.mem[7]), 32'h00001234);

      // Idle hold.
      idle(0, 10);
      check("idle_ready", 32'(ready[0]), 32'd1);
      check("idle_we_n", 32'(we_n[0]), 32'd1);
      check("idle_oe_n", 32'(oe_n[0]), 32'd1);
      check("idle_readData", rdata[0], 32'hDEADBEEF);

      // Simultaneous read and write: the write wins.
      access(0, 1'b1, 1'b1, 32'd1028, 32'hA5A5A5A5);
      idle(0, 1);
      check("sram0_w2", 32'(u_sram0.mem[2]), 32'h0000A5A5);
      check("sram0_w3", 32'(u_sram0.mem[3]), 32'h0000A5A5);
      check("rw_readData", rdata[0], 32'hDEADBEEF);

      // Reset in the second cycle of WR_HI.
      w_en[0] = 1'b1; addr[0] = 32'd1024; wdata[0] = 32'h11112222;
      repeat (4) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      @(posedge clk); #1;
      rst[0] = 1'b0; w_en[0] = 1'b0;
      check("abort_we_n", 32'(we_n[0]), 32'd1);
      check("abort_dq_oe", 32'(dq_oe[0]), 32'd0);
      check("abort_readData", rdata[0], 32'h0);
      check("abort_addr", 32'(s_addr[0]), 32'h0);
      @(posedge clk); #1;
      check("abort_sram_lo", 32'(u_sram0.mem[0]), 32'h00002222);
      check("abort_sram_hi", 32'(u_sram0.mem[1]), 32'h0000DEAD);
      access(0, 1'b1, 1'b0, 32'd1024, 32'h0);
      check("abort_read", rdata[0], 32'hDEAD2222);
      idle(0, 2);

      // ACCESS_CYCLES = 3: preload, then back-to-back reads.
      access(1, 1'b0, 1'b1, 32'd1024, 32'hCAFEF00D);
      idle(1, 1);
      access(1, 1'b0, 1'b1, 32'd1028, 32'h01234567);
      idle(1, 1);
      access(1, 1'b1, 1'b0, 32'd1024, 32'h0);
      check("b2b_read0", rdata[1], 32'hCAFEF00D);
      access(1, 1'b1, 1'b0, 32'd1028, 32'h0);
      check("b2b_read1", rdata[1], 32'h01234567);
      idle(1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
